muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide datapath. It sits beside the single-cycle integer ALU in the execute stage. The core hands it operands through a valid/ready request port, stalls while it runs, and collects a tagged result through a valid/ready response port. It computes one result bit per cycle, with single-cycle fast paths for the RISC-V divide special cases.

---
 rtl/muldiv_iter.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit, one result bit per cycle
//
// Parameters:
//   XLEN   operand/result width (>= 4)
//   TAG_W  width of the opaque tag carried from request to response
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake; in_op (funct3), in_rv1, in_rv2, in_tag
//   kill                       abort the in-flight operation
//   busy                       high whenever not idle
//   out_valid/out_ready        response handshake; out_rvout, out_tag

module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rv1,
  input  logic [XLEN-1:0]  in_rv2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rvout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;      // negate the magnitude result in FIX
  logic [XLEN-1:0]   opb;        // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc;        // {partial product, remaining multiplier bits}
  logic [XLEN-1:0]   rem;        // divide partial remainder
  logic [XLEN-1:0]   quo;        // dividend bits shifted out, quotient bits shifted in

  // Request decode
  logic            accept;
  logic            is_div;
  logic            sgn1_op;
  logic            sgn2_op;
  logic            s1;
  logic            s2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] min_int;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !kill;

  always_comb begin
    min_int           = '0;
    min_int[XLEN-1]   = 1'b1;
    is_div            = in_op[2];
    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 for MUL/MULH/DIV/REM
    sgn1_op           = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                        (in_op == OP_DIV) || (in_op == OP_REM);
    sgn2_op           = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                        (in_op == OP_DIV) || (in_op == OP_REM);
    s1                = sgn1_op && in_rv1[XLEN-1];
    s2                = sgn2_op && in_rv2[XLEN-1];
    mag1              = s1 ? (XLEN'(0) - in_rv1) : in_rv1;
    mag2              = s2 ? (XLEN'(0) - in_rv2) : in_rv2;
    div_by_zero       = is_div && (in_rv2 == '0);
    div_ovf           = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                        (in_rv1 == min_int) && (in_rv2 == '1);
    fast_res          = '0;
    if (div_by_zero) begin
      fast_res = in_op[1] ? in_rv1 : '1;
    end else if (div_ovf) begin
      fast_res = in_op[1] ? '0 : in_rv1;
    end
  end

  // Multiply step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right by one.
  logic [XLEN:0] mul_sum;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  end

  // Divide step: restoring shift-subtract on an XLEN+1 bit partial remainder.
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;
  logic          div_ge;

  always_comb begin
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = !div_diff[XLEN];
  end

  // Final sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_q ? ((2*XLEN)'(0) - acc) : acc;
    quo_fix  = neg_q ? (XLEN'(0) - quo) : quo;
    rem_fix  = neg_q ? (XLEN'(0) - rem) : rem;
    case (op_q)
      OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quo_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      opb       <= '0;
      acc       <= '0;
      rem       <= '0;
      quo       <= '0;
      out_rvout <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= in_op;
            out_tag <= in_tag;
            // remainder takes the dividend sign; product and quotient take the xor
            neg_q   <= (is_div && in_op[1]) ? s1 : (s1 ^ s2);
            cnt     <= CW'(XLEN - 1);
            if (div_by_zero || div_ovf) begin
              out_rvout <= fast_res;
              state     <= S_DONE;
            end else begin
              if (is_div) begin
                opb <= mag2;
                rem <= '0;
                quo <= mag1;
              end else begin
                opb <= mag1;
                acc <= {{XLEN{1'b0}}, mag2};
              end
              state <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            if (op_q[2]) begin
              rem <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
              quo <= {quo[XLEN-2:0], div_ge};
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            if (cnt == '0) begin
              state <= S_FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        S_FIX: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            out_rvout <= fix_res;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          // kill and out_ready both retire the operation
          if (kill || out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - directed self-checking bench for muldiv_iter

module tb_muldiv_iter;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_rv1;
  logic [XLEN-1:0]  in_rv2;
  logic [TAG_W-1:0] in_tag;
  logic             kill;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rvout;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rv1    (in_rv1),
    .in_rv2    (in_rv2),
    .in_tag    (in_tag),
    .kill      (kill),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rvout (out_rvout),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and wait for out_valid; returns the observed latency in cycles.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int lat);
    in_valid = 1'b1;
    in_op    = op;
    in_rv1   = a;
    in_rv2   = b;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
    in_rv1   = 32'hDEAD_BEEF;
    in_rv2   = 32'h1234_5678;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    check({name, "_ready"}, in_ready, 1'b1);
    issue(op, a, b, tag, lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, out_rvout, exp);
    check({name, "_tag"}, out_tag, tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rv1    = '0;
    in_rv2    = '0;
    in_tag    = '0;
    kill      = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_outs", {out_valid, busy, out_rvout, out_tag}, '0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1'b1);

    // MUL with busy observed over the run
    in_valid = 1'b1; in_op = 3'd0; in_rv1 = 32'd7; in_rv2 = 32'hFFFF_FFFD; in_tag = 5'd9;
    step();
    in_valid = 1'b0;
    seen = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy) seen++;
      step();
      lat++;
    end
    check("mul_busy", seen, 33);
    check("mul_lat", lat, 34);
    check("mul_res", out_rvout, 32'hFFFF_FFEB);
    check("mul_tag", out_tag, 5'd9);
    // hold out_ready low: output must be stable and no new request accepted
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      step();
      check("hold", {out_valid, in_ready, out_rvout, out_tag}, {2'b10, 32'hFFFF_FFEB, 5'd9});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mul_after_hs", {out_valid, in_ready, busy}, 3'b010);

    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 34);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 34);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFF, 34);
    run_op("remu",   3'd7, 32'd100,       32'd7,         5'd7, 32'd2,         34);
    run_op("divu0",  3'd5, 32'd5,         32'd0,         5'd8, 32'hFFFF_FFFF, 1);
    run_op("rem0",   3'd6, 32'd5,         32'd0,         5'd10, 32'd5,        1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        1);

    // DIVU with a request pulsed during BUSY; it must be ignored
    in_valid = 1'b1; in_op = 3'd5; in_rv1 = 32'd100; in_rv2 = 32'd7; in_tag = 5'd6;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    in_valid = 1'b1; in_op = 3'd0; in_rv1 = 32'd1; in_rv2 = 32'd1; in_tag = 5'd31;
    check("busy_no_ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0;
    lat = 5;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("divu_lat", lat, 34);
    check("divu_res", {out_rvout, out_tag}, {32'd14, 5'd6});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy) seen++;
      step();
    end
    check("no_ghost", seen, 0);

    // kill in BUSY at T+10
    in_valid = 1'b1; in_op = 3'd4; in_rv1 = 32'd1000; in_rv2 = 32'd3; in_tag = 5'd13;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      step();
      lat++;
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill_idle", {busy, in_ready}, 2'b01);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("kill_no_valid", seen, 0);
    run_op("mul34", 3'd0, 32'd3, 32'd4, 5'd14, 32'd12, 34);

    // asynchronous reset in the middle of BUSY
    in_valid = 1'b1; in_op = 3'd0; in_rv1 = 32'd5; in_rv2 = 32'd6; in_tag = 5'd15;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("rst_mid", {out_valid, busy, out_rvout, out_tag}, '0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("rst_mid_ready", in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
